fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end for the 5-stage MIPS pipeline, sitting directly upstream of the IF/ID register. Issues word fetches to a variable-latency instruction memory over a valid/ready request channel, buffers in-order responses in a DEPTH-entry FIFO, and presents instruction plus PC+4 to IF/ID with a valid/ready handshake. Redirects from jr/j/jal/taken branch flush the queue and discard in-flight responses.

## Interface
- DEPTH, 4: FIFO entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- redirect  in  1  flush and restart fetch at redirect_pc (pipeline flush_if_id).
- redirect_pc  in  32  new fetch address, word aligned.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  32  fetch address.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  one response word, in request order, no backpressure.
- imem_resp_data  in  32  instruction word.
- out_valid  out  1  head entry valid.
- out_instr  out  32  head instruction.
- out_pc4  out  32  head instruction address + 4.
- out_ready  in  1  IF/ID consumes head (ifid_write).

## Operation
- State: fetch_pc, resp_pc, FIFO {instr, pc4} with count, outstanding (accepted, unanswered requests), discard (outstanding requests to drop), started flag; counters clog2(DEPTH+1) bits.
- imem_req_valid = started & ~redirect & (count + outstanding < DEPTH); imem_req_addr = fetch_pc.
- Request accepted when valid & ready: fetch_pc += 4 (mod 2^32), outstanding += 1.
- Each response: outstanding -= 1. If redirect or discard != 0: dropped, discard -= 1 if nonzero. Else pushed as {imem_resp_data, resp_pc + 4}; resp_pc += 4.
- Pop when out_valid & out_ready & ~redirect.
- Redirect cycle: FIFO count := 0; fetch_pc, resp_pc := redirect_pc; discard := outstanding − resp_valid; no request issued, no push, no pop.
- Credit rule guarantees no overflow; push and pop in same cycle legal at any count, count unchanged.
- Request withdrawal by redirect while imem_req_ready low is permitted on this interface.
- out_valid = (count != 0); out_instr/out_pc4 reflect head; hold last popped values when empty.

## Timing
- Reset (async assert): fetch_pc = resp_pc = RESET_PC, count = outstanding = discard = 0, started = 0; imem_req_valid = 0, imem_req_addr = RESET_PC, out_valid = 0, out_instr = 0, out_pc4 = 0.
- started sets on first clk edge after reset_n rises; first request visible that cycle.
- Response earliest one cycle after acceptance; pushed data visible on out_* the cycle after imem_resp_valid.
- Zero-wait memory, out_ready = 1: one instruction per cycle sustained, 2-cycle request-to-out latency.
- imem_req_addr stable while imem_req_valid & ~imem_req_ready, except on redirect.
- Redirect: first new request in the cycle after redirect; redirect simultaneous with response, pop, or request-ready: all three suppressed.
- Reset mid-operation: all state cleared immediately; responses to pre-reset requests are external responsibility (memory also reset).

## Test plan
- Reset release, ready = 1, 1-cycle memory returning word = address, out_ready = 1 -> out_pc4 = 4, 8, 12, … one per cycle, out_instr = 0, 4, 8; first out_valid 2 cycles after first request.
- out_ready = 0 for 20 cycles -> exactly 4 requests accepted, imem_req_valid low thereafter, count = 4; release -> pops 0, 4, 8, 12 in order, fetching resumes at 0x10.
- imem_req_ready low 5 cycles with request pending -> imem_req_addr constant, no out activity beyond buffered entries.
- 3-cycle memory, 2 outstanding, redirect_pc = 0x100 -> both stale responses dropped, next out_pc4 = 0x104, out_instr = word at 0x100.
- Redirect coincident with resp_valid, out_ready and req_ready -> no push, no pop, no acceptance; discard = outstanding − 1; subsequent stream starts at redirect_pc.
- reset_n pulsed low mid-stream (FIFO = 3) -> out_valid and imem_req_valid drop asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited requests to imem, in-order response FIFO,
// head presented to IF/ID with PC+4. A redirect flushes the FIFO and drops in-flight responses.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc4,
    input  logic        out_ready
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic          started;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];
    logic [31:0]   last_instr;
    logic [31:0]   last_pc4;

    logic [CW:0]   credit_used;
    logic          accept;
    logic          push;
    logic          pop;

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a slot.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = started & ~redirect & (credit_used < DEPTH_W);
    assign imem_req_addr  = fetch_pc;

    assign accept    = imem_req_valid & imem_req_ready;
    assign out_valid = (count != '0);
    assign push      = imem_resp_valid & ~redirect & (discard == '0);
    assign pop       = out_valid & out_ready & ~redirect;

    assign out_instr = out_valid ? instr_mem[rd_ptr] : last_instr;
    assign out_pc4   = out_valid ? pc4_mem[rd_ptr]   : last_pc4;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            started     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            last_instr  <= '0;
            last_pc4    <= '0;
        end else begin
            started <= 1'b1;
            if (redirect) begin
                fetch_pc    <= redirect_pc;
                resp_pc     <= redirect_pc;
                count       <= '0;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                outstanding <= outstanding - CW'(imem_resp_valid);
                discard     <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
                if (imem_resp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + AW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr     <= rd_ptr + AW'(1);
                    last_instr <= instr_mem[rd_ptr];
                    last_pc4   <= pc4_mem[rd_ptr];
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_resp_data;
            pc4_mem[wr_ptr]   <= resp_pc + 32'd4;
        end
    end
endmodule
